hex_word_loader: RTL and testbench
==================================

Name: hex_word_loader

Overview:
- Sits between the Serial receiver and the RISC-V processor memory-load port.
- Consumes ASCII bytes from the UART receive side and parses hexadecimal text into 32-bit words.
- Writes each parsed word into consecutive memory slots, then issues a one-cycle start pulse to the processor on command.
- Reports status (word count, sticky error flags) for LEDs.

Parameters:
- NUM_WORDS, 16, number of writable memory slots; index wraps is forbidden (see full rule).
- IDX_W, 4, width of slot index; must satisfy 2**IDX_W >= NUM_WORDS.
- MAX_DIGITS, 8, maximum hex digits per word (8 gives 32 bits).

Ports:
- i_Clk  input  1  system clock (50 MHz).
- i_Rst_n  input  1  asynchronous, active-low reset.
- i_rx_data  input  8  received byte from Serial.
- i_rx_valid  input  1  one-cycle pulse; i_rx_data is valid in that cycle.
- i_proc_busy  input  1  processor is running; loader must not write memory.
- o_wr_en  output  1  one-cycle memory write strobe.
- o_wr_index  output  IDX_W  slot index for the write.
- o_wr_data  output  32  word to write.
- o_start  output  1  one-cycle pulse requesting processor start.
- o_word_count  output  IDX_W+1  words written since last clear (0..NUM_WORDS).
- o_err_char  output  1  sticky: illegal character seen.
- o_err_ovf  output  1  sticky: word exceeded MAX_DIGITS, or write attempted while full.
- o_err_busy  output  1  sticky: byte arrived while i_proc_busy.

Behaviour:
- Reset (async, i_Rst_n=0): all outputs 0, accumulator 0, digit count 0, index 0, state S_IDLE. Reset mid-word discards the partial word.
- Byte classes:
  - digit: '0'-'9', 'A'-'F', 'a'-'f'.
  - sep: 0x20, 0x0D, 0x0A.
  - go: '!' (0x21).
  - clr: '#' (0x23).
  - everything else is illegal.
- States:
  - S_IDLE: no pending digits.
  - S_DIGITS: at least 1 pending digit.
  - S_SKIP: discarding the rest of a bad token until the next sep, go or clr.
  - S_GO: emit start after a pending write.
- digit:
  - acc <= {acc[27:0], nibble}; dcnt++; IDLE -> DIGITS.
  - If dcnt == MAX_DIGITS already: set o_err_ovf, clear acc/dcnt, go to S_SKIP.
- sep:
  - In DIGITS, commit the word: registered o_wr_en=1 in the cycle after i_rx_valid, with o_wr_index=index and o_wr_data=acc zero-extended. Then index++, count++, acc/dcnt cleared, go to IDLE.
  - In IDLE it is a no-op. In SKIP it goes to IDLE.
- Full rule: a commit when count == NUM_WORDS produces no write, sets o_err_ovf and discards the word. The index never wraps.
- go:
  - From IDLE or SKIP: o_start pulses 1 cycle after i_rx_valid.
  - From DIGITS: commit first (write at N+1), then o_start at N+2 via S_GO.
  - If count == 0: o_start still pulses.
- clr: index, count, acc, dcnt and all three error flags go to 0; state goes to IDLE. No write is issued.
- Illegal byte: set o_err_char, clear acc/dcnt, go to S_SKIP. In S_SKIP, digits are ignored.
- i_proc_busy=1 when i_rx_valid arrives: the byte is dropped and o_err_busy is set. The parser state is frozen, except that clr is always honoured.
- Strobes: o_wr_en and o_start are never high in the same cycle, and each is exactly 1 cycle wide.
- Throughput: i_rx_valid pulses are spaced at least 3 cycles apart (UART rate), so no input buffering is required. The S_GO extra cycle never collides with the next byte.
- o_word_count saturates at NUM_WORDS.

Decomposition:
- Shared package: ASCII constants (CH_SEP_SP, CH_CR, CH_LF, CH_GO, CH_CLR) and the state encoding localparams (S_IDLE, S_DIGITS, S_SKIP, S_GO).
- Sub-module ascii_hex_decode (combinational): byte -> {is_digit, nibble[3:0], is_sep, is_go, is_clr}. It is reused later by the transmit formatter.

Test Plan:
- Send "1234abcd\r" -> one o_wr_en with index 0, data 0x1234ABCD; o_word_count=1; no error flags.
- Send "FF 7\n!" -> writes (0, 0x000000FF) then (1, 0x00000007), then a single o_start pulse; count=2.
- Send "12!" -> write (0, 0x00000012) at N+1, o_start at N+2, never in the same cycle.
- Send "123456789 " then "5 " -> o_err_ovf=1, no write for the first token; second token writes (0, 0x5).
- Send "4G2 3 " -> o_err_char=1, "4G2" discarded, write (0, 0x3). Then "#" clears flags and count. Then 17 words with NUM_WORDS=16 -> 16 writes, indices 0..15, o_err_ovf=1, count=16.
- Hold i_proc_busy=1 and send "AB " -> no write, o_err_busy=1. Drop i_Rst_n mid-token ("12" then reset) -> all outputs 0; after release, "9 " writes (0, 0x9).

Source files
------------

// File: rtl/hex_word_loader_pkg.sv
// Shared constants and types for the hex word loader and its helpers.
package hex_word_loader_pkg;

  // Control characters recognised in the incoming text stream.
  localparam logic [7:0] CH_SEP_SP = 8'h20;
  localparam logic [7:0] CH_CR     = 8'h0D;
  localparam logic [7:0] CH_LF     = 8'h0A;
  localparam logic [7:0] CH_GO     = 8'h21;
  localparam logic [7:0] CH_CLR    = 8'h23;

  // Parser states.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIGITS = 2'd1,
    S_SKIP   = 2'd2,
    S_GO     = 2'd3
  } state_e;

  // Classification of one received byte.
  typedef struct packed {
    logic       is_digit;
    logic [3:0] nibble;
    logic       is_sep;
    logic       is_go;
    logic       is_clr;
  } char_class_t;

endpackage

// File: rtl/hex_word_loader_if.sv
// Byte-in / memory-write-out bundle between the UART side, the loader and the processor.
interface hex_word_loader_if #(
  parameter int unsigned IDX_W = 4
);

  logic [7:0]     i_rx_data;
  logic           i_rx_valid;
  logic           i_proc_busy;
  logic           o_wr_en;
  logic [IDX_W-1:0] o_wr_index;
  logic [31:0]    o_wr_data;
  logic           o_start;
  logic [IDX_W:0] o_word_count;
  logic           o_err_char;
  logic           o_err_ovf;
  logic           o_err_busy;

  // Loader side.
  modport slave (
    input  i_rx_data, i_rx_valid, i_proc_busy,
    output o_wr_en, o_wr_index, o_wr_data, o_start, o_word_count,
    output o_err_char, o_err_ovf, o_err_busy
  );

  // Environment side (receiver, processor, status LEDs).
  modport master (
    output i_rx_data, i_rx_valid, i_proc_busy,
    input  o_wr_en, o_wr_index, o_wr_data, o_start, o_word_count,
    input  o_err_char, o_err_ovf, o_err_busy
  );

endinterface

// File: rtl/hex_word_loader_ascii_hex_decode.sv
// Combinational ASCII classifier: hex digit value plus separator / go / clear flags.
module ascii_hex_decode
  import hex_word_loader_pkg::*;
(
  input  logic [7:0]  byte_i,
  output char_class_t class_o
);

  // Classify the byte; nibble is only meaningful when is_digit is set.
  always_comb begin
    class_o = '0;
    if (byte_i >= 8'h30 && byte_i <= 8'h39) begin
      class_o.is_digit = 1'b1;
      class_o.nibble   = byte_i[3:0];
    end else if ((byte_i >= 8'h41 && byte_i <= 8'h46) ||
                 (byte_i >= 8'h61 && byte_i <= 8'h66)) begin
      class_o.is_digit = 1'b1;
      // Letters A-F / a-f have low bits 1..6; add 9 to land on 10..15.
      class_o.nibble   = byte_i[3:0] + 4'd9;
    end
    class_o.is_sep = (byte_i == CH_SEP_SP) || (byte_i == CH_CR) || (byte_i == CH_LF);
    class_o.is_go  = (byte_i == CH_GO);
    class_o.is_clr = (byte_i == CH_CLR);
  end

endmodule

// File: rtl/hex_word_loader.sv
// Parses hex text from the UART into 32-bit words, writes them to consecutive memory
// slots and raises a one-cycle processor start pulse on '!'.
module hex_word_loader
  import hex_word_loader_pkg::*;
#(
  parameter int unsigned NUM_WORDS  = 16,
  parameter int unsigned IDX_W      = 4,
  parameter int unsigned MAX_DIGITS = 8
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  hex_word_loader_if.slave bus
);

  localparam int unsigned DCNT_W = $clog2(MAX_DIGITS + 1);

  char_class_t cls;

  state_e              state_q, state_d;
  logic [31:0]         acc_q, acc_d;
  logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W:0]      cnt_q, cnt_d;
  logic                wr_en_q, wr_en_d;
  logic [IDX_W-1:0]    wr_index_q, wr_index_d;
  logic [31:0]         wr_data_q, wr_data_d;
  logic                start_q, start_d;
  logic                err_char_q, err_char_d;
  logic                err_ovf_q, err_ovf_d;
  logic                err_busy_q, err_busy_d;

  // Per-byte actions derived from the current state and the decoded byte.
  logic act_clr, busy_drop, take;
  logic act_push, act_dovf, act_term, act_commit, act_go, act_char;
  logic dig_full, mem_full;

  ascii_hex_decode u_decode (
    .byte_i  (bus.i_rx_data),
    .class_o (cls)
  );

  assign dig_full = (dcnt_q == DCNT_W'(MAX_DIGITS));
  assign mem_full = (cnt_q == (IDX_W + 1)'(NUM_WORDS));

  // Decode the incoming byte into the action it triggers this cycle.
  always_comb begin
    act_clr    = bus.i_rx_valid && cls.is_clr;
    busy_drop  = bus.i_rx_valid && bus.i_proc_busy && !cls.is_clr;
    // S_GO lasts a single cycle and byte spacing keeps it clear of new input.
    take       = bus.i_rx_valid && !bus.i_proc_busy && !cls.is_clr && (state_q != S_GO);
    act_push   = take && cls.is_digit && (state_q != S_SKIP) && !dig_full;
    act_dovf   = take && cls.is_digit && (state_q != S_SKIP) && dig_full;
    act_term   = take && (cls.is_sep || cls.is_go);
    act_commit = act_term && (state_q == S_DIGITS);
    act_go     = take && cls.is_go;
    act_char   = take && !cls.is_digit && !cls.is_sep && !cls.is_go;
  end

  // State register and all datapath flops.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      dcnt_q     <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_index_q <= '0;
      wr_data_q  <= '0;
      start_q    <= 1'b0;
      err_char_q <= 1'b0;
      err_ovf_q  <= 1'b0;
      err_busy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      dcnt_q     <= dcnt_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      wr_en_q    <= wr_en_d;
      wr_index_q <= wr_index_d;
      wr_data_q  <= wr_data_d;
      start_q    <= start_d;
      err_char_q <= err_char_d;
      err_ovf_q  <= err_ovf_d;
      err_busy_q <= err_busy_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (state_q == S_GO) begin
      state_d = S_IDLE;
    end
    if (act_clr) begin
      state_d = S_IDLE;
    end else if (act_push) begin
      state_d = S_DIGITS;
    end else if (act_dovf || act_char) begin
      state_d = S_SKIP;
    end else if (act_term) begin
      // A go that commits a word delays start by one cycle so write and start never overlap.
      state_d = (act_go && act_commit) ? S_GO : S_IDLE;
    end
  end

  // Datapath, strobes and sticky flags.
  always_comb begin
    acc_d      = acc_q;
    dcnt_d     = dcnt_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    wr_en_d    = 1'b0;
    wr_index_d = wr_index_q;
    wr_data_d  = wr_data_q;
    start_d    = (state_q == S_GO) || (act_go && !act_commit);
    err_char_d = err_char_q;
    err_ovf_d  = err_ovf_q;
    err_busy_d = err_busy_q;

    if (act_clr) begin
      acc_d      = '0;
      dcnt_d     = '0;
      idx_d      = '0;
      cnt_d      = '0;
      err_char_d = 1'b0;
      err_ovf_d  = 1'b0;
      err_busy_d = 1'b0;
    end else begin
      if (busy_drop) begin
        err_busy_d = 1'b1;
      end
      if (act_push) begin
        acc_d  = {acc_q[27:0], cls.nibble};
        dcnt_d = dcnt_q + 1'b1;
      end
      if (act_dovf || act_char || act_commit) begin
        acc_d  = '0;
        dcnt_d = '0;
      end
      if (act_dovf) begin
        err_ovf_d = 1'b1;
      end
      if (act_char) begin
        err_char_d = 1'b1;
      end
      if (act_commit) begin
        if (mem_full) begin
          err_ovf_d = 1'b1;
        end else begin
          wr_en_d    = 1'b1;
          wr_index_d = idx_q;
          wr_data_d  = acc_q;
          cnt_d      = cnt_q + 1'b1;
          // Index stops at the last slot; the full check blocks any further write.
          if (idx_q != IDX_W'(NUM_WORDS - 1)) begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
    end
  end

  assign bus.o_wr_en      = wr_en_q;
  assign bus.o_wr_index   = wr_index_q;
  assign bus.o_wr_data    = wr_data_q;
  assign bus.o_start      = start_q;
  assign bus.o_word_count = cnt_q;
  assign bus.o_err_char   = err_char_q;
  assign bus.o_err_ovf    = err_ovf_q;
  assign bus.o_err_busy   = err_busy_q;

endmodule

// File: tb/tb_hex_word_loader.sv
// Self-checking bench: directed text sequences plus random bytes against a token-level model.
module tb_hex_word_loader;

  localparam int unsigned NumWords = 16;
  localparam int unsigned IdxW     = 4;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  hex_word_loader_if #(.IDX_W(IdxW)) bus ();

  hex_word_loader #(
    .NUM_WORDS  (NumWords),
    .IDX_W      (IdxW),
    .MAX_DIGITS (8)
  ) dut (
    .i_Clk   (clk),
    .i_Rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Reference model: text-level view of tokens, slots and flags.
  bit [31:0] m_val;
  int        m_nd;
  bit        m_skip;
  int        m_cnt;
  bit        m_ec, m_eo, m_eb;
  bit        exp_wr;
  int        exp_idx;
  bit [31:0] exp_data;
  int        exp_start_off;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_hex(input logic [7:0] b);
    return (b >= "0" && b <= "9") || (b >= "a" && b <= "f") || (b >= "A" && b <= "F");
  endfunction

  function automatic int hex_val(input logic [7:0] b);
    if (b >= "0" && b <= "9") return int'(b) - 48;
    if (b >= "a" && b <= "f") return int'(b) - 97 + 10;
    return int'(b) - 65 + 10;
  endfunction

  task automatic model_reset();
    m_val = 0; m_nd = 0; m_skip = 0; m_cnt = 0;
    m_ec = 0; m_eo = 0; m_eb = 0;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit busy);
    bit had;
    exp_wr = 0;
    exp_start_off = 0;
    if (b == "#") begin
      model_reset();
    end else if (busy) begin
      m_eb = 1;
    end else if (is_hex(b)) begin
      if (!m_skip) begin
        if (m_nd == 8) begin
          m_eo = 1; m_skip = 1; m_nd = 0; m_val = 0;
        end else begin
          m_val = m_val * 16 + 32'(hex_val(b));
          m_nd++;
        end
      end
    end else if (b == 8'h20 || b == 8'h0D || b == 8'h0A || b == "!") begin
      had = (m_nd > 0);
      if (had) begin
        if (m_cnt < NumWords) begin
          exp_wr = 1; exp_idx = m_cnt; exp_data = m_val; m_cnt++;
        end else begin
          m_eo = 1;
        end
      end
      m_nd = 0; m_val = 0; m_skip = 0;
      if (b == "!") exp_start_off = had ? 2 : 1;
    end else begin
      m_ec = 1; m_skip = 1; m_nd = 0; m_val = 0;
    end
  endtask

  task automatic check_status(input string tag);
    check_eq({tag, ".count"}, 32'(bus.o_word_count), 32'(m_cnt));
    check_eq({tag, ".err_char"}, 32'(bus.o_err_char), 32'(m_ec));
    check_eq({tag, ".err_ovf"}, 32'(bus.o_err_ovf), 32'(m_eo));
    check_eq({tag, ".err_busy"}, 32'(bus.o_err_busy), 32'(m_eb));
  endtask

  // One byte per 4 cycles; strobes are checked at each of the three following negedges.
  task automatic send_byte(input logic [7:0] b, input bit busy);
    model_byte(b, busy);
    @(negedge clk);
    bus.i_rx_data   = b;
    bus.i_rx_valid  = 1'b1;
    bus.i_proc_busy = busy;
    for (int off = 1; off <= 3; off++) begin
      @(negedge clk);
      if (off == 1) begin
        bus.i_rx_valid  = 1'b0;
        bus.i_proc_busy = 1'b0;
      end
      check_eq("wr_en", 32'(bus.o_wr_en), 32'(exp_wr && off == 1));
      if (exp_wr && off == 1) begin
        check_eq("wr_index", 32'(bus.o_wr_index), 32'(exp_idx));
        check_eq("wr_data", bus.o_wr_data, exp_data);
      end
      check_eq("start", 32'(bus.o_start), 32'(exp_start_off == off));
    end
    check_status("status");
  endtask

  task automatic send_str(input string s, input bit busy);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], busy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.i_rx_valid  = 1'b0;
    bus.i_proc_busy = 1'b0;
    #1;
    check_eq("rst.wr_en", 32'(bus.o_wr_en), 0);
    check_eq("rst.wr_index", 32'(bus.o_wr_index), 0);
    check_eq("rst.wr_data", bus.o_wr_data, 0);
    check_eq("rst.start", 32'(bus.o_start), 0);
    model_reset();
    check_status("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    string alpha_hex;
    string alpha_bad;
    logic [7:0] b;
    int r;
    total = 0;
    bad   = 0;
    alpha_hex = "0123456789abcdefABCDEF";
    alpha_bad = "GgZz@.xq~$";
    rst_n = 1'b0;
    bus.i_rx_data   = 8'h00;
    bus.i_rx_valid  = 1'b0;
    bus.i_proc_busy = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();

    send_str("1234abcd\r", 1'b0);
    send_str("#FF 7\n!", 1'b0);
    send_str("#12!", 1'b0);
    send_str("#123456789 5 ", 1'b0);
    send_str("#4G2 3 ", 1'b0);
    send_str("#", 1'b0);
    for (int i = 0; i < 17; i++) send_str($sformatf("%0h ", i + 1), 1'b0);
    check_eq("full.count", 32'(bus.o_word_count), 32'(NumWords));
    check_eq("full.ovf", 32'(bus.o_err_ovf), 1);
    send_str("#", 1'b0);
    send_str("AB ", 1'b1);
    send_str("12", 1'b0);
    do_reset();
    send_str("9 ", 1'b0);
    send_str("!", 1'b0);

    // Random byte stream with occasional busy cycles and resets.
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 99);
      if (r < 60) b = alpha_hex[$urandom_range(0, alpha_hex.len() - 1)];
      else if (r < 70) b = 8'h20;
      else if (r < 73) b = 8'h0D;
      else if (r < 76) b = 8'h0A;
      else if (r < 81) b = "!";
      else if (r < 84) b = "#";
      else b = alpha_bad[$urandom_range(0, alpha_bad.len() - 1)];
      if ($urandom_range(0, 299) == 0) do_reset();
      send_byte(b, $urandom_range(0, 11) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
